icb_slave_regfile: RTL and testbench
====================================

// Module: icb_slave_regfile
// PURPOSE
//  Synthesizable ICB target: bank of 32-bit registers behind one ICB slave port.
//  Responder end of the ICB command/response protocol driven by our master BFM and bus masters.
//  One outstanding transaction. Byte-masked writes. Programmable response latency.
//  Errors on out-of-range or misaligned access.
// PARAMETERS
//  NUM_REGS     16            number of 32-bit registers (>=1)
//  BASE_ADDR    32'h1000_0000 byte address of register 0 (4-byte aligned)
//  RSP_LATENCY  1             clock edges from cmd accept to rsp_valid rising (>=1)
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  rst            in   1   asynchronous reset, active-high
//  icb_cmd_valid  in   1   command valid
//  icb_cmd_ready  out  1   command ready
//  icb_cmd_addr   in   32  byte address
//  icb_cmd_read   in   1   1=read, 0=write
//  icb_cmd_wdata  in   32  write data
//  icb_cmd_wmask  in   4   byte-lane write enables, bit i -> wdata[8i+7:8i]
//  icb_rsp_valid  out  1   response valid
//  icb_rsp_ready  in   1   response ready
//  icb_rsp_rdata  out  32  read data (0 for writes and errors)
//  icb_rsp_err    out  1   error flag
// BEHAVIOUR
//  Reset (async assert, sync release)
//  - State=IDLE. All registers=0.
//  - icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, icb_cmd_ready=0 while rst=1.
//  - Reset mid-transaction drops the pending response. No partial write survives.
//  FSM: IDLE -> WAIT -> RESP -> IDLE
//  - IDLE: icb_cmd_ready=1. Accept edge = edge with cmd_valid&cmd_ready.
//    At the accept edge: decode, commit any write, capture rdata/err.
//    Then go to RESP if RSP_LATENCY==1, else WAIT with cnt=RSP_LATENCY-2.
//  - WAIT: icb_cmd_ready=0. Decrement cnt each edge. Go to RESP at the edge where cnt==0.
//  - RESP: icb_rsp_valid=1, icb_cmd_ready=0.
//    rdata/err stay stable until the edge with rsp_valid&rsp_ready, then go to IDLE.
//    rsp_valid drops and cmd_ready rises in the following cycle.
//  - rsp_valid rises exactly RSP_LATENCY edges after the accept edge.
//  - Minimum turnaround is RSP_LATENCY+1 cycles per transaction.
//  Decode (combinational on cmd_addr)
//  - off = addr - BASE_ADDR (32-bit unsigned, wraps).
//  - hit = (addr >= BASE_ADDR) && (off < NUM_REGS*4).
//  - idx = off[.. :2].
//  - err = !hit || addr[1:0] != 2'b00.
//  Write, no error: reg[idx] byte i <= wdata byte i when wmask[i]=1.
//  - wmask=4'b0000 is a legal no-op with err=0.
//  Write, error: no register changes. rsp_err=1, rsp_rdata=0.
//  Read, no error: rsp_rdata = reg[idx] as held at the accept edge, so a read after a write sees the new value.
//  - wmask is ignored on reads.
//  Read, error: rsp_rdata=0, rsp_err=1.
//  cmd inputs are don't-care outside IDLE. rsp_ready is don't-care outside RESP.
//  NUM_REGS*4 must not overflow 32 bits. Elaboration fails if RSP_LATENCY<1.
// TESTING
//  1. Write 0xDEADBEEF @0x1000_0004, wmask=F; read @0x1000_0004
//     -> rsp_err=0, rdata=0xDEADBEEF, rsp_valid 1 edge after accept (L=1).
//  2. Reg 2 = 0x11223344; write 0xAABBCCDD, wmask=4'b0101; read
//     -> rdata=0x11BB33DD.
//  3. Access outside the register window:
//     - write @0x1000_0040 (NUM_REGS=16) -> err=1, no reg changes.
//     - read @0x0FFF_FFFC -> err=1, rdata=0.
//  4. Misaligned read @0x1000_0006 -> err=1, rdata=0. Register 1 is unchanged.
//  5. Latency and backpressure, RSP_LATENCY=4:
//     - rsp_valid rises on the 4th edge after accept.
//     - Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, cmd_ready=0 throughout.
//     - Raise rsp_ready -> cmd_ready=1 next cycle.
//  6. Assert rst during WAIT after a write to reg 3 -> rsp_valid never rises, reg 3 reads 0 after reset.

Source files
------------

// File: rtl/icb_slave_regfile.sv
// ICB slave holding a bank of 32-bit registers with byte-masked writes,
// one outstanding transaction and a fixed, programmable response latency.
module icb_slave_regfile #(
   parameter int unsigned NUM_REGS    = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          RSP_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icb_cmd_valid,
   output logic        icb_cmd_ready,
   input  logic [31:0] icb_cmd_addr,
   input  logic        icb_cmd_read,
   input  logic [31:0] icb_cmd_wdata,
   input  logic [3:0]  icb_cmd_wmask,
   output logic        icb_rsp_valid,
   input  logic        icb_rsp_ready,
   output logic [31:0] icb_rsp_rdata,
   output logic        icb_rsp_err
);

   localparam int          IW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);
   localparam logic [31:0] CNT_INIT  = (RSP_LATENCY >= 2) ? 32'(RSP_LATENCY - 2) : 32'd0;

   generate
      if (RSP_LATENCY < 1) begin : g_badLatency
         $error("icb_slave_regfile: RSP_LATENCY must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_cnt;
   logic [31:0] w_cntNext;
   logic [31:0] r_regs [NUM_REGS];
   logic [31:0] r_rdata;
   logic        r_err;

   logic [31:0] w_off;
   logic        w_hit;
   logic        w_err;
   logic [IW-1:0] w_idx;
   logic [31:0] w_rdVal;
   logic        w_accept;

   // The offset wraps, so addresses below the base are rejected by the explicit compare.
   assign w_off    = icb_cmd_addr - BASE_ADDR;
   assign w_hit    = (icb_cmd_addr >= BASE_ADDR) && (w_off < WIN_BYTES);
   assign w_idx    = w_off[IW+1:2];
   assign w_err    = !w_hit || (icb_cmd_addr[1:0] != 2'b00);
   assign w_rdVal  = w_hit ? r_regs[w_idx] : 32'd0;
   assign w_accept = (r_state == ST_IDLE) && icb_cmd_valid;

   assign icb_cmd_ready = (r_state == ST_IDLE) && !rst;
   assign icb_rsp_valid = (r_state == ST_RESP);
   assign icb_rsp_rdata = r_rdata;
   assign icb_rsp_err   = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 32'd0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (icb_cmd_valid) begin
               if (RSP_LATENCY == 1) begin
                  w_stateNext = ST_RESP;
               end else begin
                  w_stateNext = ST_WAIT;
                  w_cntNext   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == 32'd0) begin
               w_stateNext = ST_RESP;
            end else begin
               w_cntNext = r_cnt - 32'd1;
            end
         end
         ST_RESP: begin
            if (icb_rsp_ready) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // Writes commit and read data is captured at the accept edge; the response holds it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_regs[i] <= 32'd0;
         end
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_err   <= w_err;
         r_rdata <= (icb_cmd_read && !w_err) ? w_rdVal : 32'd0;
         if (!icb_cmd_read && !w_err) begin
            for (int b = 0; b < 4; b++) begin
               if (icb_cmd_wmask[b]) begin
                  r_regs[w_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_icb_slave_regfile.sv
// Directed bench for icb_slave_regfile: a latency-1 instance for decode/data
// behaviour and a latency-4 instance for timing, backpressure and reset abort.
module tb_icb_slave_regfile;

   logic        clk;
   logic        rst;
   logic [31:0] cmdAddr;
   logic        cmdRead;
   logic [31:0] cmdWdata;
   logic [3:0]  cmdWmask;
   logic        cmdValid1, cmdValid4;
   logic        rspReady1, rspReady4;
   logic        cmdReady1, cmdReady4;
   logic        rspValid1, rspValid4;
   logic [31:0] rspRdata1, rspRdata4;
   logic        rspErr1, rspErr4;

   int checkCount;
   int errorCount;

   icb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h1000_0000), .RSP_LATENCY(1)) uFast (
      .clk           (clk),
      .rst           (rst),
      .icb_cmd_valid (cmdValid1),
      .icb_cmd_ready (cmdReady1),
      .icb_cmd_addr  (cmdAddr),
      .icb_cmd_read  (cmdRead),
      .icb_cmd_wdata (cmdWdata),
      .icb_cmd_wmask (cmdWmask),
      .icb_rsp_valid (rspValid1),
      .icb_rsp_ready (rspReady1),
      .icb_rsp_rdata (rspRdata1),
      .icb_rsp_err   (rspErr1)
   );

   icb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h1000_0000), .RSP_LATENCY(4)) uSlow (
      .clk           (clk),
      .rst           (rst),
      .icb_cmd_valid (cmdValid4),
      .icb_cmd_ready (cmdReady4),
      .icb_cmd_addr  (cmdAddr),
      .icb_cmd_read  (cmdRead),
      .icb_cmd_wdata (cmdWdata),
      .icb_cmd_wmask (cmdWmask),
      .icb_rsp_valid (rspValid4),
      .icb_rsp_ready (rspReady4),
      .icb_rsp_rdata (rspRdata4),
      .icb_rsp_err   (rspErr4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // One full transaction; holdCycles keeps rsp_ready low after rsp_valid rises.
   task automatic applyStimulus(input string tag, input bit slow, input bit isRead,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask, input int holdCycles, input int expLat,
                                input logic [31:0] expData, input bit expErr);
      int n;
      n = 0;
      while (!(slow ? cmdReady4 : cmdReady1) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!(slow ? cmdReady4 : cmdReady1)) begin
         checkOutput({tag, "_cmdReadyTimeout"}, 32'(slow ? cmdReady4 : cmdReady1), 32'd1);
         return;
      end
      cmdAddr  = addr;
      cmdRead  = isRead;
      cmdWdata = wdata;
      cmdWmask = mask;
      if (slow) cmdValid4 = 1'b1; else cmdValid1 = 1'b1;
      @(posedge clk); #1;
      cmdValid1 = 1'b0;
      cmdValid4 = 1'b0;
      n = 1;
      while (!(slow ? rspValid4 : rspValid1) && n < 20) begin
         checkOutput({tag, "_cmdReadyInWait"}, 32'(slow ? cmdReady4 : cmdReady1), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
      if (!(slow ? rspValid4 : rspValid1)) return;
      checkOutput({tag, "_rdata"}, slow ? rspRdata4 : rspRdata1, expData);
      checkOutput({tag, "_err"}, 32'(slow ? rspErr4 : rspErr1), 32'(expErr));
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk); #1;
         checkOutput({tag, "_holdValid"}, 32'(slow ? rspValid4 : rspValid1), 32'd1);
         checkOutput({tag, "_holdRdata"}, slow ? rspRdata4 : rspRdata1, expData);
         checkOutput({tag, "_holdCmdReady"}, 32'(slow ? cmdReady4 : cmdReady1), 32'd0);
      end
      if (slow) rspReady4 = 1'b1; else rspReady1 = 1'b1;
      @(posedge clk); #1;
      rspReady1 = 1'b0;
      rspReady4 = 1'b0;
      checkOutput({tag, "_validDropped"}, 32'(slow ? rspValid4 : rspValid1), 32'd0);
      checkOutput({tag, "_cmdReadyBack"}, 32'(slow ? cmdReady4 : cmdReady1), 32'd1);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst       = 1'b1;
      cmdAddr   = 32'd0;
      cmdRead   = 1'b0;
      cmdWdata  = 32'd0;
      cmdWmask  = 4'd0;
      cmdValid1 = 1'b0;
      cmdValid4 = 1'b0;
      rspReady1 = 1'b0;
      rspReady4 = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cmdReady", 32'(cmdReady1), 32'd0);
      checkOutput("rst_rspValid", 32'(rspValid1), 32'd0);
      checkOutput("rst_rdata", rspRdata1, 32'd0);
      checkOutput("rst_err", 32'(rspErr1), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("postRst_cmdReady", 32'(cmdReady1), 32'd1);

      // Basic write then read back
      applyStimulus("t1_wr", 0, 0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0, 0);
      applyStimulus("t1_rd", 0, 1, 32'h1000_0004, 32'h0, 4'hF, 0, 1, 32'hDEAD_BEEF, 0);

      // Byte-masked merge and the empty-mask no-op
      applyStimulus("t2_init", 0, 0, 32'h1000_0008, 32'h1122_3344, 4'hF, 0, 1, 32'h0, 0);
      applyStimulus("t2_mask", 0, 0, 32'h1000_0008, 32'hAABB_CCDD, 4'b0101, 0, 1, 32'h0, 0);
      applyStimulus("t2_rd", 0, 1, 32'h1000_0008, 32'h0, 4'h0, 0, 1, 32'h11BB_33DD, 0);
      applyStimulus("t2_noop", 0, 0, 32'h1000_0008, 32'hFFFF_FFFF, 4'h0, 0, 1, 32'h0, 0);
      applyStimulus("t2_rdNoop", 0, 1, 32'h1000_0008, 32'h0, 4'h0, 0, 1, 32'h11BB_33DD, 0);

      // Window edges
      applyStimulus("t3_wrLast", 0, 0, 32'h1000_003C, 32'h0BAD_F00D, 4'hF, 0, 1, 32'h0, 0);
      applyStimulus("t3_wrOut", 0, 0, 32'h1000_0040, 32'h1234_5678, 4'hF, 0, 1, 32'h0, 1);
      applyStimulus("t3_rdLast", 0, 1, 32'h1000_003C, 32'h0, 4'hF, 0, 1, 32'h0BAD_F00D, 0);
      applyStimulus("t3_rdReg0", 0, 1, 32'h1000_0000, 32'h0, 4'hF, 0, 1, 32'h0, 0);
      applyStimulus("t3_rdBelow", 0, 1, 32'h0FFF_FFFC, 32'h0, 4'hF, 0, 1, 32'h0, 1);

      // Misalignment
      applyStimulus("t4_rdMis", 0, 1, 32'h1000_0006, 32'h0, 4'hF, 0, 1, 32'h0, 1);
      applyStimulus("t4_wrMis", 0, 0, 32'h1000_0005, 32'h5555_5555, 4'hF, 0, 1, 32'h0, 1);
      applyStimulus("t4_rdReg1", 0, 1, 32'h1000_0004, 32'h0, 4'hF, 0, 1, 32'hDEAD_BEEF, 0);

      // Latency 4 with backpressure
      applyStimulus("t5_wr", 1, 0, 32'h1000_0014, 32'hCAFE_F00D, 4'hF, 0, 4, 32'h0, 0);
      applyStimulus("t5_rdHold", 1, 1, 32'h1000_0014, 32'h0, 4'hF, 5, 4, 32'hCAFE_F00D, 0);

      // Reset while a write is in WAIT
      cmdAddr   = 32'h1000_000C;
      cmdRead   = 1'b0;
      cmdWdata  = 32'h55AA_55AA;
      cmdWmask  = 4'hF;
      cmdValid4 = 1'b1;
      @(posedge clk); #1;
      cmdValid4 = 1'b0;
      checkOutput("t6_inWait", 32'(cmdReady4), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("t6_rstValid", 32'(rspValid4), 32'd0);
      checkOutput("t6_rstCmdReady", 32'(cmdReady4), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput("t6_noRsp", 32'(rspValid4), 32'd0);
      end
      applyStimulus("t6_rdReg3", 1, 1, 32'h1000_000C, 32'h0, 4'hF, 0, 4, 32'h0, 0);
      applyStimulus("t6_rdFastReg1", 0, 1, 32'h1000_0004, 32'h0, 4'hF, 0, 1, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
